// File: rtl/mux_n_pipe.sv
// NUM_IN-way select mux feeding a registered output stage with a 2-entry skid buffer.
// Illegal selects capture 0 and are reported through sel_err and a saturating err_cnt.
module mux_n_pipe #(
  parameter int N = 32,
  parameter int NUM_IN = 3,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [NUM_IN*N-1:0] in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N-1:0]        out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sel_err,
  output logic [7:0]          err_cnt,
  output logic [1:0]          state_dbg
);

  // Handshake: a word moves on an interface only in a cycle where valid & ready are both
  // high at the rising edge; valid never waits for ready, and in_ready is purely registered.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state, state_next;
  logic [N-1:0] skid_data;
  logic [N-1:0] mux_data;
  logic         sel_illegal;
  logic         accept, deliver;
  logic         load_out, load_skid, out_from_skid;

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) mux_data = in_data[k*N +: N];
    end
  end

  assign sel_illegal = ({1'b0, in_sel} >= (SEL_W+1)'(NUM_IN));
  assign out_valid   = (state != EMPTY);
  assign accept      = in_valid & in_ready;
  assign deliver     = out_valid & out_ready;
  assign state_dbg   = state;

  always_comb begin
    state_next    = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          load_out   = 1'b1;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (deliver) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          state_next    = ONE;
          out_from_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Flush overrides every transfer decided above.
    if (flush) begin
      state_next    = EMPTY;
      load_out      = 1'b0;
      load_skid     = 1'b0;
      out_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_data  <= '0;
      skid_data <= '0;
      in_ready  <= 1'b0;
      sel_err   <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != FULL);
      sel_err  <= accept & sel_illegal & ~flush;
      if (accept && sel_illegal && !flush && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (load_out) out_data <= mux_data;
      else if (out_from_skid) out_data <= skid_data;
      if (load_skid) skid_data <= mux_data;
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: directed scenarios on a 3-input instance, randomized
// traffic on a 5-input instance against a queue-based reference model.
module tb_mux_n_pipe;

  logic clk;
  logic rst;

  // 3-input instance (directed)
  logic [95:0] d3_data;
  logic [1:0]  d3_sel;
  logic        d3_valid, d3_in_ready, d3_out_valid, d3_out_ready, d3_flush, d3_sel_err;
  logic [31:0] d3_out_data;
  logic [7:0]  d3_err_cnt;
  logic [1:0]  d3_state;

  // 5-input instance (random)
  logic [159:0] r_data;
  logic [2:0]   r_sel;
  logic         r_valid, r_in_ready, r_out_valid, r_out_ready, r_flush, r_sel_err;
  logic [31:0]  r_out_data;
  logic [7:0]   r_err_cnt;
  logic [1:0]   r_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  int          m_cnt;
  bit          m_rdy, m_serr;

  mux_n_pipe #(.N(32), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst(rst), .flush(d3_flush), .in_data(d3_data), .in_sel(d3_sel),
    .in_valid(d3_valid), .in_ready(d3_in_ready), .out_data(d3_out_data),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .sel_err(d3_sel_err),
    .err_cnt(d3_err_cnt), .state_dbg(d3_state)
  );

  mux_n_pipe #(.N(32), .NUM_IN(5)) u_dut5 (
    .clk(clk), .rst(rst), .flush(r_flush), .in_data(r_data), .in_sel(r_sel),
    .in_valid(r_valid), .in_ready(r_in_ready), .out_data(r_out_data),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .sel_err(r_sel_err),
    .err_cnt(r_err_cnt), .state_dbg(r_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load_a_b_stalled();
    d3_out_ready = 1'b0;
    d3_valid = 1'b1; d3_sel = 2'd0; cyc();
    d3_sel = 2'd1; cyc();
    chk("fill_ready", 32'(d3_in_ready), 32'd0);
  endtask

  task automatic d3_check_out(input string tag, input logic v, input logic [31:0] d, input logic rdy);
    chk({tag, "_valid"}, 32'(d3_out_valid), 32'(v));
    if (v) chk({tag, "_data"}, d3_out_data, d);
    chk({tag, "_ready"}, 32'(d3_in_ready), 32'(rdy));
  endtask

  logic [31:0] wa, wb, wc, word;
  bit acc, del, ill;

  initial begin
    wa = 32'h11111111; wb = 32'h22222222; wc = 32'h33333333;
    rst = 1'b1;
    d3_data = {wc, wb, wa}; d3_sel = '0; d3_valid = 1'b0; d3_out_ready = 1'b0; d3_flush = 1'b0;
    r_data = '0; r_sel = '0; r_valid = 1'b0; r_out_ready = 1'b0; r_flush = 1'b0;

    // Reset: two cycles held
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_valid", 32'(d3_out_valid), 32'd0);
      chk("rst_data", d3_out_data, 32'd0);
      chk("rst_errcnt", 32'(d3_err_cnt), 32'd0);
      chk("rst_ready", 32'(d3_in_ready), 32'd0);
      chk("rst_selerr", 32'(d3_sel_err), 32'd0);
    end
    rst = 1'b0;
    cyc();
    chk("rel_ready", 32'(d3_in_ready), 32'd1);

    // Select sweep, streaming with out_ready high
    d3_out_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      d3_sel = 2'(s); d3_valid = 1'b1;
      cyc();
      d3_check_out("sweep", 1'b1, d3_data[s*32 +: 32], 1'b1);
      chk("sweep_selerr", 32'(d3_sel_err), 32'd0);
    end
    d3_valid = 1'b0;
    cyc();
    chk("sweep_drain", 32'(d3_out_valid), 32'd0);

    // Illegal select
    d3_sel = 2'd3; d3_valid = 1'b1;
    cyc();
    d3_check_out("ill", 1'b1, 32'd0, 1'b1);
    chk("ill_selerr", 32'(d3_sel_err), 32'd1);
    chk("ill_errcnt", 32'(d3_err_cnt), 32'd1);
    d3_valid = 1'b0;
    cyc();
    chk("ill_pulse_end", 32'(d3_sel_err), 32'd0);
    chk("ill_errcnt_hold", 32'(d3_err_cnt), 32'd1);
    d3_valid = 1'b1;
    for (int i = 0; i < 299; i++) begin
      cyc();
      if (i == 252) chk("ill_errcnt_fe", 32'(d3_err_cnt), 32'hFE);
    end
    d3_valid = 1'b0;
    cyc();
    chk("ill_errcnt_sat", 32'(d3_err_cnt), 32'hFF);
    chk("ill_last_selerr", 32'(d3_sel_err), 32'd0);

    // Backpressure: A on output, B in skid, C held upstream
    d3_out_ready = 1'b0;
    d3_sel = 2'd0; d3_valid = 1'b1;
    cyc(); d3_check_out("bp_a", 1'b1, wa, 1'b1);
    d3_sel = 2'd1;
    cyc(); d3_check_out("bp_b", 1'b1, wa, 1'b0);
    d3_sel = 2'd2;
    cyc(); d3_check_out("bp_c1", 1'b1, wa, 1'b0);
    cyc(); d3_check_out("bp_c2", 1'b1, wa, 1'b0);
    d3_out_ready = 1'b1;
    cyc(); d3_check_out("bp_rel_b", 1'b1, wb, 1'b1);
    cyc(); d3_check_out("bp_rel_c", 1'b1, wc, 1'b1);
    d3_valid = 1'b0;
    cyc(); chk("bp_drain", 32'(d3_out_valid), 32'd0);

    // Flush while FULL with D offered
    load_a_b_stalled();
    d3_flush = 1'b1; d3_valid = 1'b1; d3_sel = 2'd2;
    cyc();
    chk("fl_valid", 32'(d3_out_valid), 32'd0);
    chk("fl_ready", 32'(d3_in_ready), 32'd1);
    chk("fl_errcnt", 32'(d3_err_cnt), 32'hFF);
    d3_flush = 1'b0; d3_valid = 1'b0; d3_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("fl_no_d", 32'(d3_out_valid), 32'd0);
    end

    // Reset mid-transfer drops both entries and clears err_cnt
    load_a_b_stalled();
    rst = 1'b1; d3_valid = 1'b0;
    cyc();
    chk("rmid_valid", 32'(d3_out_valid), 32'd0);
    chk("rmid_data", d3_out_data, 32'd0);
    chk("rmid_errcnt", 32'(d3_err_cnt), 32'd0);
    chk("rmid_ready", 32'(d3_in_ready), 32'd0);
    rst = 1'b0; d3_out_ready = 1'b1;
    cyc();
    chk("rmid_rel_valid", 32'(d3_out_valid), 32'd0);
    chk("rmid_rel_ready", 32'(d3_in_ready), 32'd1);

    // Illegal select offered during flush is dropped silently
    d3_flush = 1'b1; d3_valid = 1'b1; d3_sel = 2'd3;
    cyc();
    chk("flill_selerr", 32'(d3_sel_err), 32'd0);
    chk("flill_errcnt", 32'(d3_err_cnt), 32'd0);
    chk("flill_valid", 32'(d3_out_valid), 32'd0);
    d3_flush = 1'b0; d3_valid = 1'b0;
    cyc();
    chk("flill_selerr2", 32'(d3_sel_err), 32'd0);
    chk("flill_errcnt2", 32'(d3_err_cnt), 32'd0);
    chk("flill_valid2", 32'(d3_out_valid), 32'd0);

    // Random traffic on the 5-input instance
    exp_q.delete(); m_cnt = 0; m_rdy = 1'b1; m_serr = 1'b0;
    for (int it = 0; it < 10000; it++) begin
      chk("r_nox", 32'($isunknown({r_out_data, r_out_valid, r_in_ready, r_sel_err, r_err_cnt})), 32'd0);
      chk("r_valid", 32'(r_out_valid), 32'(exp_q.size() > 0));
      chk("r_ready", 32'(r_in_ready), 32'(m_rdy));
      chk("r_selerr", 32'(r_sel_err), 32'(m_serr));
      chk("r_errcnt", 32'(r_err_cnt), 32'(m_cnt));
      if (exp_q.size() > 0) chk("r_data", r_out_data, exp_q[0]);

      rst = (it == 5000 || it == 5001);
      for (int k = 0; k < 5; k++) r_data[k*32 +: 32] = $urandom;
      r_sel       = 3'($urandom_range(0, 7));
      r_valid     = ($urandom_range(0, 9) < 7);
      r_out_ready = ($urandom_range(0, 9) < 6);
      r_flush     = ($urandom_range(0, 99) == 0);

      ill  = (r_sel >= 3'd5);
      word = ill ? 32'd0 : r_data[r_sel*32 +: 32];
      if (rst) begin
        exp_q.delete(); m_rdy = 1'b0; m_serr = 1'b0; m_cnt = 0;
      end else if (r_flush) begin
        exp_q.delete(); m_rdy = 1'b1; m_serr = 1'b0;
      end else begin
        acc = r_valid && m_rdy;
        del = (exp_q.size() > 0) && r_out_ready;
        if (del) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(word);
        m_serr = acc && ill;
        if (acc && ill && m_cnt < 255) m_cnt++;
        m_rdy = (exp_q.size() < 2);
      end
      cyc();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
